multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port instr  input  DATA_WIDTH  instruction register contents; valid from DECODE onward.
REQ-005 SHALL have port EQ  input  1  ALU equality flag, rs1 == rs2.
REQ-006 SHALL have port mem_ready  input  1  memory completes the current request this cycle.
REQ-007 SHALL have port mem_req  output  1  memory request.
REQ-008 SHALL have port AdrSrc  output  1  memory address: 0 = PC, 1 = ALUOut.
REQ-009 SHALL have port IRWrite  output  1  load instruction register.
REQ-010 SHALL have port PCWrite  output  1  load PC.
REQ-011 SHALL have port PCsrc  output  1  PC source: 0 = Result, 1 = ALUOut.
REQ-012 SHALL have port RegWrite  output  1  register file write.
REQ-013 SHALL have port ALUsrcA  output  2  ALU operand A: 00 = PC, 01 = oldPC, 10 = rs1.
REQ-014 SHALL have port ALUsrcB  output  2  ALU operand B: 00 = rs2, 01 = imm, 10 = constant 4.
REQ-015 SHALL have port ALUctrl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-016 SHALL have port ImmSrc  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
REQ-017 SHALL have port ResultSrc  output  2  result source: 00 = ALUOut, 01 = data register, 10 = ALU result.
REQ-018 SHALL have ports MEMWrite  output  4  byte-write enables, and MEMRead  output  3  read mode.
REQ-019 SHALL have ports illegal  output  1, instr_done  output  1, and state_o  output  4.

Function
REQ-020 SHALL implement a Moore FSM with these state_o encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECI 6, ALUWB 7, BRANCH 8, LINK 9, JALR 10, ILLEGAL 11.
REQ-021 FETCH SHALL drive:
- mem_req = 1, AdrSrc = 0.
- ALUsrcA = 00, ALUsrcB = 10, ALUctrl = 000.
- ResultSrc = 10, PCsrc = 0.
- IRWrite = PCWrite = mem_ready.
- Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
REQ-022 DECODE SHALL compute the branch/jump target with ALUsrcA = 01, ALUsrcB = 01, ALUctrl = 000, and ImmSrc per opcode. Next state by opcode:
- 0000011 or 0100011 -> MEMADR.
- 0010011 -> EXECI.
- 1100011 -> BRANCH.
- 1101111 -> LINK.
- 1100111 with funct3 000 -> JALR.
- anything else -> ILLEGAL.
REQ-023 MEMADR SHALL drive ALUsrcA = 10, ALUsrcB = 01, ALUctrl = 000; next state is MEMREAD for loads, MEMWRITE for stores.
REQ-024 MEMREAD SHALL drive mem_req = 1, AdrSrc = 1, and MEMRead by funct3:
- 010 -> 111.
- 000 or 100 -> 000.
- Hold until mem_ready = 1, then go to MEMWB.
REQ-025 MEMWB SHALL drive ResultSrc = 01, RegWrite = 1, then go to FETCH.
REQ-026 MEMWRITE SHALL drive mem_req = 1, AdrSrc = 1, and MEMWrite by funct3:
- 010 -> 1111.
- 000 -> 0001.
- Hold until mem_ready = 1, then go to FETCH.
REQ-027 EXECI SHALL drive ALUsrcA = 10, ALUsrcB = 01, and ALUctrl by funct3 (000 -> 000, 110 -> 011, 010 -> 101, 111 -> 010), then go to ALUWB.
REQ-028 ALUWB SHALL drive ResultSrc = 00, RegWrite = 1, then go to FETCH.
REQ-029 BRANCH SHALL drive:
- ALUsrcA = 10, ALUsrcB = 00, ALUctrl = 001, PCsrc = 1.
- PCWrite = (funct3 000 AND EQ) OR (funct3 001 AND NOT EQ).
- Next state FETCH.
REQ-030 JALR SHALL drive ALUsrcA = 10, ALUsrcB = 01, ALUctrl = 000, then go to LINK.
REQ-031 LINK SHALL drive:
- ALUsrcA = 01, ALUsrcB = 10, ALUctrl = 000.
- ResultSrc = 10, RegWrite = 1.
- PCsrc = 1, PCWrite = 1.
- Next state FETCH.
REQ-032 An unsupported funct3 for an opcode in REQ-022 SHALL go to ILLEGAL.
REQ-033 ILLEGAL SHALL be absorbing: all enables and mem_req = 0, illegal = 1, held until reset.
REQ-034 Outputs not listed for a state SHALL be 0, except ALUctrl = 111 and MEMRead = 111.
REQ-035 mem_req SHALL remain asserted with constant AdrSrc, MEMWrite and MEMRead until the cycle mem_ready = 1.
REQ-036 mem_ready SHALL be ignored in states without mem_req.
REQ-037 instr_done SHALL pulse for 1 cycle on every transition into FETCH from any other state.

Reset
REQ-038 While rst_n = 0, the controller SHALL set state = FETCH and illegal = 0, and force all outputs to 0 except state_o = 0.
REQ-039 Reset assertion SHALL take effect immediately and asynchronously, including mid-request; the aborted access SHALL NOT be retried.
REQ-040 On the first clk edge after rst_n rises, the controller SHALL begin FETCH with mem_req = 1.

Verification
REQ-041 Test: addi (0x00500093), mem_ready = 1 -> states 0,1,6,7,0; RegWrite only in ALUWB; instr_done in cycle 5.
REQ-042 Test: lw (funct3 010), mem_ready low 2 cycles in MEMREAD -> MEMREAD held 3 cycles with MEMRead = 111 and AdrSrc = 1 constant; then MEMWB with RegWrite = 1.
REQ-043 Test: sb (0100011 / 000) -> MEMWrite = 0001 only in MEMWRITE; 4 states total.
REQ-044 Test: beq with EQ = 1 -> PCWrite = 1, PCsrc = 1 in BRANCH; beq with EQ = 0 -> PCWrite = 0; bne inverts.
REQ-045 Test: jalr (1100111 / 000) -> states 0,1,10,9,0; LINK has RegWrite = PCWrite = PCsrc = 1. Opcode 0110111 -> ILLEGAL sticky until rst_n pulse.
REQ-046 Test: rst_n asserted during MEMWRITE with mem_ready = 0 -> all outputs 0 immediately; after release, state_o = 0 and mem_req = 1.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset controller: a Moore FSM sequencing fetch, decode,
// memory, ALU-immediate, branch and jump steps over a shared memory port.
module multicycle_controller #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  EQ,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  AdrSrc,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  PCsrc,
  output logic                  RegWrite,
  output logic [1:0]            ALUsrcA,
  output logic [1:0]            ALUsrcB,
  output logic [2:0]            ALUctrl,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            ResultSrc,
  output logic [3:0]            MEMWrite,
  output logic [2:0]            MEMRead,
  output logic                  illegal,
  output logic                  instr_done,
  output logic [3:0]            state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECI    = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_LINK     = 4'd9,
    S_JALR     = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  state_t     state_q, state_d;
  logic       instr_done_q, instr_done_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign unused_instr_bits = ^{instr[DATA_WIDTH-1:15], instr[11:7]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_done_q <= instr_done_d;
    end
  end

  // Unsupported funct3 values are rejected here so later states never see them.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD:  state_d = (funct3 == 3'b010 || funct3 == 3'b000 || funct3 == 3'b100)
                              ? S_MEMADR : S_ILLEGAL;
          OP_STORE: state_d = (funct3 == 3'b010 || funct3 == 3'b000) ? S_MEMADR : S_ILLEGAL;
          OP_IMM:   state_d = (funct3 == 3'b000 || funct3 == 3'b110 ||
                               funct3 == 3'b010 || funct3 == 3'b111) ? S_EXECI : S_ILLEGAL;
          OP_BR:    state_d = (funct3 == 3'b000 || funct3 == 3'b001) ? S_BRANCH : S_ILLEGAL;
          OP_JAL:   state_d = S_LINK;
          OP_JALR:  state_d = (funct3 == 3'b000) ? S_JALR : S_ILLEGAL;
          default:  state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JALR:     state_d = S_LINK;
      S_LINK:     state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
    instr_done_d = (state_d == S_FETCH) && (state_q != S_FETCH);
  end

  always_comb begin
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCsrc     = 1'b0;
    RegWrite  = 1'b0;
    ALUsrcA   = 2'b00;
    ALUsrcB   = 2'b00;
    ALUctrl   = 3'b111;
    ImmSrc    = 2'b00;
    ResultSrc = 2'b00;
    MEMWrite  = 4'b0000;
    MEMRead   = 3'b111;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUsrcB   = 2'b10;
        ALUctrl   = 3'b000;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUsrcA = 2'b01;
        ALUsrcB = 2'b01;
        ALUctrl = 3'b000;
        case (opcode)
          OP_STORE: ImmSrc = 2'b01;
          OP_BR:    ImmSrc = 2'b10;
          OP_JAL:   ImmSrc = 2'b11;
          default:  ImmSrc = 2'b00;
        endcase
      end
      S_MEMADR: begin
        ALUsrcA = 2'b10;
        ALUsrcB = 2'b01;
        ALUctrl = 3'b000;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        MEMRead = (funct3 == 3'b000 || funct3 == 3'b100) ? 3'b000 : 3'b111;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MEMWrite = (funct3 == 3'b010) ? 4'b1111 :
                   (funct3 == 3'b000) ? 4'b0001 : 4'b0000;
      end
      S_EXECI: begin
        ALUsrcA = 2'b10;
        ALUsrcB = 2'b01;
        case (funct3)
          3'b000:  ALUctrl = 3'b000;
          3'b110:  ALUctrl = 3'b011;
          3'b010:  ALUctrl = 3'b101;
          3'b111:  ALUctrl = 3'b010;
          default: ALUctrl = 3'b111;
        endcase
      end
      S_ALUWB: begin
        ResultSrc = 2'b00;
        RegWrite  = 1'b1;
      end
      S_BRANCH: begin
        ALUsrcA = 2'b10;
        ALUsrcB = 2'b00;
        ALUctrl = 3'b001;
        PCsrc   = 1'b1;
        PCWrite = ((funct3 == 3'b000) && EQ) || ((funct3 == 3'b001) && !EQ);
      end
      S_JALR: begin
        ALUsrcA = 2'b10;
        ALUsrcB = 2'b01;
        ALUctrl = 3'b000;
      end
      S_LINK: begin
        ALUsrcA   = 2'b01;
        ALUsrcB   = 2'b10;
        ALUctrl   = 3'b000;
        ResultSrc = 2'b10;
        RegWrite  = 1'b1;
        PCsrc     = 1'b1;
        PCWrite   = 1'b1;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
    // Reset blanks every output immediately, including an in-flight request.
    if (!rst_n) begin
      mem_req   = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCsrc     = 1'b0;
      RegWrite  = 1'b0;
      ALUsrcA   = 2'b00;
      ALUsrcB   = 2'b00;
      ALUctrl   = 3'b000;
      ImmSrc    = 2'b00;
      ResultSrc = 2'b00;
      MEMWrite  = 4'b0000;
      MEMRead   = 3'b000;
      illegal   = 1'b0;
    end
  end

  assign instr_done = instr_done_q;
  assign state_o    = state_q;

endmodule
